// File: rtl/axis_hdr_insert_reg_if.sv
// AXI-Stream bus bundle used for the header, payload and packed output ports
// of the header inserter.
interface axis_hdr_insert_reg_if #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WD-1:0]      tdata;
  logic [DATA_BYTE_WD-1:0] tkeep;
  logic                    tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_hdr_insert_reg.sv
// AXI-Stream header inserter: prepends an optional 0..N byte header beat to each
// payload packet, byte-packs the result into a registered output stage, counts packets.
module axis_hdr_insert_reg #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned CNT_WD       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insert_en,
  axis_hdr_insert_reg_if.slave  s00_axis,
  axis_hdr_insert_reg_if.slave  s01_axis,
  axis_hdr_insert_reg_if.master m_axis,
  output logic [CNT_WD-1:0]     pkt_cnt
);

  localparam int unsigned N      = DATA_BYTE_WD;
  localparam int unsigned LEN_WD = $clog2(N + 1);
  localparam int unsigned SUM_WD = $clog2(2 * N + 1);
  localparam int unsigned SH_WD  = $clog2(DATA_WD + 1);
  localparam logic [N-1:0] KEEP_ALL = '1;

  typedef enum logic [1:0] {IDLE, STREAM, TAIL, PASS} state_e;

  state_e              state_q, state_d;
  logic [DATA_WD-1:0]  residue_q, residue_d;
  logic [LEN_WD-1:0]   hdr_len_q, hdr_len_d;
  logic [LEN_WD-1:0]   tail_len_q, tail_len_d;

  logic                m_valid_q;
  logic [DATA_WD-1:0]  m_data_q;
  logic [N-1:0]        m_keep_q;
  logic                m_last_q;
  logic [CNT_WD-1:0]   pkt_cnt_q;

  logic                ofree_c;
  logic                s00_ready_c;
  logic                s01_ready_c;
  logic                ld_c;
  logic [DATA_WD-1:0]  ld_data_c;
  logic [N-1:0]        ld_keep_c;
  logic                ld_last_c;
  logic [LEN_WD-1:0]   pay_len_c;
  logic [SUM_WD-1:0]   sum_len_c;
  logic [SH_WD-1:0]    shamt_c;
  logic [2*DATA_WD-1:0] shifted_c;

  logic                unused_hdr_tlast;
  assign unused_hdr_tlast = s00_axis.tlast;

  function automatic logic [LEN_WD-1:0] popcnt(input logic [N-1:0] k);
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) c = c + LEN_WD'(k[i]);
    return c;
  endfunction

  // n MSB-aligned keep bits; n may exceed N, which saturates to all ones
  function automatic logic [N-1:0] keep_msb(input logic [SUM_WD-1:0] n);
    logic [N-1:0] k;
    k = '0;
    for (int i = 0; i < int'(N); i++) k[N-1-i] = (SUM_WD'(i) < n);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < int'(N); i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign ofree_c   = !m_valid_q || m_axis.tready;
  assign pay_len_c = popcnt(s01_axis.tkeep);
  assign sum_len_c = SUM_WD'(hdr_len_q) + SUM_WD'(pay_len_c);
  assign shamt_c   = SH_WD'(hdr_len_q) << 3;

  // Upper half: payload moved down behind the H residue bytes.
  // Lower half: the H payload bytes that spill into the next beat, left-justified.
  assign shifted_c = {s01_axis.tdata, {DATA_WD{1'b0}}} >> shamt_c;

  assign s00_axis.tready = s00_ready_c;
  assign s01_axis.tready = s01_ready_c;
  assign m_axis.tvalid   = m_valid_q;
  assign m_axis.tdata    = m_data_q;
  assign m_axis.tkeep    = m_keep_q;
  assign m_axis.tlast    = m_last_q;
  assign pkt_cnt         = pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, input readies and the candidate load for the output register
  always_comb begin
    state_d     = state_q;
    residue_d   = residue_q;
    hdr_len_d   = hdr_len_q;
    tail_len_d  = tail_len_q;
    s00_ready_c = 1'b0;
    s01_ready_c = 1'b0;
    ld_c        = 1'b0;
    ld_data_c   = '0;
    ld_keep_c   = '0;
    ld_last_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (insert_en) begin
          s00_ready_c = 1'b1;
          if (s00_axis.tvalid) begin
            hdr_len_d = popcnt(s00_axis.tkeep);
            residue_d = s00_axis.tdata & byte_mask(s00_axis.tkeep);
            state_d   = STREAM;
          end
        end else if (s01_axis.tvalid) begin
          state_d = PASS;
        end
      end

      STREAM: begin
        s01_ready_c = ofree_c;
        if (ofree_c && s01_axis.tvalid) begin
          ld_c      = 1'b1;
          residue_d = shifted_c[DATA_WD-1:0];
          ld_keep_c = KEEP_ALL;
          if (s01_axis.tlast) begin
            if (sum_len_c <= SUM_WD'(N)) begin
              ld_keep_c = keep_msb(sum_len_c);
              ld_last_c = 1'b1;
              state_d   = IDLE;
            end else begin
              tail_len_d = LEN_WD'(sum_len_c - SUM_WD'(N));
              state_d    = TAIL;
            end
          end
          ld_data_c = (residue_q | shifted_c[2*DATA_WD-1:DATA_WD]) & byte_mask(ld_keep_c);
        end
      end

      TAIL: begin
        if (ofree_c) begin
          ld_c      = 1'b1;
          ld_keep_c = keep_msb(SUM_WD'(tail_len_q));
          ld_data_c = residue_q & byte_mask(ld_keep_c);
          ld_last_c = 1'b1;
          state_d   = IDLE;
        end
      end

      PASS: begin
        s01_ready_c = ofree_c;
        if (ofree_c && s01_axis.tvalid) begin
          ld_c      = 1'b1;
          ld_data_c = s01_axis.tdata;
          ld_keep_c = s01_axis.tkeep;
          ld_last_c = s01_axis.tlast;
          if (s01_axis.tlast) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      s00_ready_c = 1'b0;
      s01_ready_c = 1'b0;
    end
  end

  // Output register, packing residue and packet counter
  always_ff @(posedge clk) begin
    if (rst) begin
      residue_q  <= '0;
      hdr_len_q  <= '0;
      tail_len_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      residue_q  <= residue_d;
      hdr_len_q  <= hdr_len_d;
      tail_len_q <= tail_len_d;
      if (ld_c) begin
        m_valid_q <= 1'b1;
        m_data_q  <= ld_data_c;
        m_keep_q  <= ld_keep_c;
        m_last_q  <= ld_last_c;
      end else if (ofree_c) begin
        m_valid_q <= 1'b0;
      end
      if (m_valid_q && m_axis.tready && m_last_q) pkt_cnt_q <= pkt_cnt_q + CNT_WD'(1);
    end
  end

endmodule

// File: tb/tb_axis_hdr_insert_reg.sv
// Directed bench for axis_hdr_insert_reg: cycle table for basic header sizes,
// plus sequences for backpressure, bypass, and mid-packet reset.
module tb_axis_hdr_insert_reg;

  logic        clk;
  logic        rst;
  logic        insert_en;
  logic [31:0] pkt_cnt;

  axis_hdr_insert_reg_if #(.DATA_WD(32), .DATA_BYTE_WD(4)) s00_if ();
  axis_hdr_insert_reg_if #(.DATA_WD(32), .DATA_BYTE_WD(4)) s01_if ();
  axis_hdr_insert_reg_if #(.DATA_WD(32), .DATA_BYTE_WD(4)) m_if ();

  axis_hdr_insert_reg #(.DATA_WD(32), .DATA_BYTE_WD(4), .CNT_WD(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .insert_en(insert_en),
    .s00_axis (s00_if),
    .s01_axis (s01_if),
    .m_axis   (m_if),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ins; logic hv; logic [31:0] hd; logic [3:0] hk;
    logic pv; logic [31:0] pd; logic [3:0] pk; logic pl;
    logic e_hr; logic e_pr; logic e_mv; logic [31:0] e_md; logic [3:0] e_mk; logic e_ml;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  vec_t  vt [15];
  beat_t got_q [$];
  beat_t exp_q [$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    base = 0;
  int    s00_seen = 0;
  logic  mon_en = 1'b0;
  logic  s00_watch = 1'b0;
  logic  toggle_rdy = 1'b0;
  logic  held_v = 1'b0;
  logic [63:0] held = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Accepted-beat collector and stall-stability checker, sampled mid-cycle
  always begin
    @(negedge clk);
    #3;
    if (rst || !mon_en) begin
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("stall_hold", 64'({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}), held);
      if (m_if.tvalid && m_if.tready) got_q.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast});
      held_v = m_if.tvalid && !m_if.tready;
      held   = 64'({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata});
      if (s00_watch && s00_if.tready) s00_seen++;
    end
  end

  task automatic step();
    @(negedge clk);
    if (toggle_rdy) m_if.tready = !m_if.tready;
  endtask

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
    s00_if.tvalid = 1'b1;
    s00_if.tdata  = d;
    s00_if.tkeep  = k;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (s00_if.tready) begin
        step();
        s00_if.tvalid = 1'b0;
        return;
      end
      step();
    end
    chk("hdr_timeout", 64'(1), 64'(0));
    s00_if.tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s01_if.tvalid = 1'b1;
    s01_if.tdata  = d;
    s01_if.tkeep  = k;
    s01_if.tlast  = l;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (s01_if.tready) begin
        step();
        s01_if.tvalid = 1'b0;
        return;
      end
      step();
    end
    chk("beat_timeout", 64'(1), 64'(0));
    s01_if.tvalid = 1'b0;
  endtask

  task automatic check_beats(input string nm);
    int n;
    n = exp_q.size();
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() >= base + n) break;
      step();
    end
    chk({nm, " beat_count"}, 64'(got_q.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size()) begin
        chk($sformatf("%s beat%0d data", nm, i), 64'(got_q[base+i].d), 64'(exp_q[i].d));
        chk($sformatf("%s beat%0d keep", nm, i), 64'(got_q[base+i].k), 64'(exp_q[i].k));
        chk($sformatf("%s beat%0d last", nm, i), 64'(got_q[base+i].l), 64'(exp_q[i].l));
      end
    end
    step();
    step();
  endtask

  initial begin
    rst           = 1'b1;
    insert_en     = 1'b1;
    s00_if.tvalid = 1'b0; s00_if.tdata = '0; s00_if.tkeep = '0; s00_if.tlast = 1'b1;
    s01_if.tvalid = 1'b0; s01_if.tdata = '0; s01_if.tkeep = '0; s01_if.tlast = 1'b0;
    m_if.tready   = 1'b1;

    //          ins   hv    hd            hk    pv    pd            pk    pl    e_hr  e_pr  e_mv  e_md          e_mk  e_ml  e_cnt
    vt[0]  = '{1'b1, 1'b1, 32'hA1A2A3FF, 4'hE, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd0};
    vt[2]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA1A2A3AA, 4'hF, 1'b0, 32'd0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBBCCDD11, 4'hF, 1'b0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22334400, 4'hE, 1'b1, 32'd0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd1};
    vt[6]  = '{1'b1, 1'b1, 32'h01020304, 4'hF, 1'b1, 32'h55AABBCC, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd1};
    vt[7]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 32'h55AABBCC, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd1};
    vt[8]  = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01020304, 4'hF, 1'b0, 32'd1};
    vt[9]  = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55000000, 4'h8, 1'b1, 32'd1};
    vt[10] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd2};
    vt[11] = '{1'b1, 1'b1, 32'h77FFFFFF, 4'h8, 1'b1, 32'h88FFFFFF, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd2};
    vt[12] = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b1, 32'h88FFFFFF, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'd2};
    vt[13] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77880000, 4'hC, 1'b1, 32'd2};
    vt[14] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 32'd3};

    repeat (3) @(negedge clk);
    #1;
    chk("reset m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("reset m_tdata", 64'(m_if.tdata), 64'(0));
    chk("reset m_tkeep", 64'(m_if.tkeep), 64'(0));
    chk("reset m_tlast", 64'(m_if.tlast), 64'(0));
    chk("reset s00_tready", 64'(s00_if.tready), 64'(0));
    chk("reset s01_tready", 64'(s01_if.tready), 64'(0));
    chk("reset pkt_cnt", 64'(pkt_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Cycle-exact table: inputs driven after the falling edge, outputs checked 1 ns later
    for (int i = 0; i < 15; i++) begin
      insert_en     = vt[i].ins;
      s00_if.tvalid = vt[i].hv; s00_if.tdata = vt[i].hd; s00_if.tkeep = vt[i].hk;
      s01_if.tvalid = vt[i].pv; s01_if.tdata = vt[i].pd; s01_if.tkeep = vt[i].pk;
      s01_if.tlast  = vt[i].pl;
      #1;
      chk($sformatf("row%0d s00_tready", i), 64'(s00_if.tready), 64'(vt[i].e_hr));
      chk($sformatf("row%0d s01_tready", i), 64'(s01_if.tready), 64'(vt[i].e_pr));
      chk($sformatf("row%0d m_tvalid", i), 64'(m_if.tvalid), 64'(vt[i].e_mv));
      chk($sformatf("row%0d pkt_cnt", i), 64'(pkt_cnt), 64'(vt[i].e_cnt));
      if (vt[i].e_mv) begin
        chk($sformatf("row%0d m_tdata", i), 64'(m_if.tdata), 64'(vt[i].e_md));
        chk($sformatf("row%0d m_tkeep", i), 64'(m_if.tkeep), 64'(vt[i].e_mk));
        chk($sformatf("row%0d m_tlast", i), 64'(m_if.tlast), 64'(vt[i].e_ml));
      end
      @(negedge clk);
    end

    // H=2, four payload beats, output ready toggling every cycle
    mon_en     = 1'b1;
    insert_en  = 1'b1;
    toggle_rdy = 1'b1;
    base       = got_q.size();
    exp_q      = {};
    exp_q.push_back('{32'hC1C21011, 4'hF, 1'b0});
    exp_q.push_back('{32'h12132021, 4'hF, 1'b0});
    exp_q.push_back('{32'h22233031, 4'hF, 1'b0});
    exp_q.push_back('{32'h32334041, 4'hF, 1'b0});
    exp_q.push_back('{32'h42430000, 4'hC, 1'b1});
    send_hdr(32'hC1C2FFFF, 4'hC);
    send_beat(32'h10111213, 4'hF, 1'b0);
    send_beat(32'h20212223, 4'hF, 1'b0);
    send_beat(32'h30313233, 4'hF, 1'b0);
    send_beat(32'h40414243, 4'hF, 1'b1);
    check_beats("stall");
    toggle_rdy  = 1'b0;
    m_if.tready = 1'b1;
    step();
    #1;
    chk("stall pkt_cnt", 64'(pkt_cnt), 64'(4));

    // Bypass with a header already waiting: packet passes bit-exact, header untouched
    insert_en     = 1'b0;
    s00_if.tvalid = 1'b1;
    s00_if.tdata  = 32'hD1D2D3D4;
    s00_if.tkeep  = 4'hF;
    s00_watch     = 1'b1;
    base          = got_q.size();
    exp_q         = {};
    exp_q.push_back('{32'h01234567, 4'hF, 1'b0});
    exp_q.push_back('{32'h89ABCDEF, 4'hC, 1'b1});
    send_beat(32'h01234567, 4'hF, 1'b0);
    send_beat(32'h89ABCDEF, 4'hC, 1'b1);
    check_beats("bypass");
    s00_watch = 1'b0;
    chk("bypass s00_tready cycles", 64'(s00_seen), 64'(0));

    // The waiting header is consumed by the next insert packet
    insert_en = 1'b1;
    base      = got_q.size();
    exp_q     = {};
    exp_q.push_back('{32'hD1D2D3D4, 4'hF, 1'b0});
    exp_q.push_back('{32'h5A000000, 4'h8, 1'b1});
    send_hdr(32'hD1D2D3D4, 4'hF);
    send_beat(32'h5AFFFFFF, 4'h8, 1'b1);
    check_beats("held_hdr");
    #1;
    chk("held_hdr pkt_cnt", 64'(pkt_cnt), 64'(6));

    // Reset while streaming discards the packet and clears the counter
    @(negedge clk);
    send_hdr(32'hE1000000, 4'h8);
    send_beat(32'h10203040, 4'hF, 1'b0);
    rst = 1'b1;
    step();
    #1;
    chk("midreset m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("midreset pkt_cnt", 64'(pkt_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Clean packet after reset, zero-byte header
    base  = got_q.size();
    exp_q = {};
    exp_q.push_back('{32'hCAFEBABE, 4'hF, 1'b0});
    exp_q.push_back('{32'h12345600, 4'hE, 1'b1});
    send_hdr(32'h0, 4'h0);
    send_beat(32'hCAFEBABE, 4'hF, 1'b0);
    send_beat(32'h12345678, 4'hE, 1'b1);
    check_beats("post_reset");
    #1;
    chk("post_reset pkt_cnt", 64'(pkt_cnt), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
